// File: rtl/fpu_long_issuer.sv
// Issue stage for a multi-cycle FP unit: accepts one op, starts the FPU, waits for its
// result (with flush and timeout handling) and presents it on a writeback handshake.
module fpu_long_issuer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic [31:0] req_z,
  input  logic [4:0]  req_funct5,
  input  logic [2:0]  req_rm,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        fpu_en,
  output logic [31:0] fpu_x,
  output logic [31:0] fpu_y,
  output logic [31:0] fpu_z,
  output logic [4:0]  fpu_funct5,
  output logic [2:0]  fpu_rm,
  input  logic [31:0] fpu_res,
  input  logic        fpu_valid,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DRAIN} state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // Handshake/strobe outputs decode straight from the state register.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign fpu_en    = (state == ISSUE);
  assign wb_valid  = (state == HOLD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
      fpu_x       <= '0;
      fpu_y       <= '0;
      fpu_z       <= '0;
      fpu_funct5  <= '0;
      fpu_rm      <= '0;
      wb_data     <= '0;
      wb_rd       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            fpu_x      <= req_x;
            fpu_y      <= req_y;
            fpu_z      <= req_z;
            fpu_funct5 <= req_funct5;
            fpu_rm     <= req_rm;
            wb_rd      <= req_rd;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (fpu_valid && flush) begin
            state <= IDLE;
          end else if (fpu_valid) begin
            wb_data <= fpu_res;
            state   <= HOLD;
          end else if (flush) begin
            state <= DRAIN;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (fpu_valid) begin
            if (!flush) begin
              wb_data <= fpu_res;
              state   <= HOLD;
            end else begin
              state <= IDLE;
            end
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            // A killed op keeps counting in DRAIN so a lost result still times out.
            cnt <= cnt + 1'b1;
            if (flush) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fpu_valid) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          // A flush here kills the writeback even if the consumer is ready.
          if (flush || wb_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_long_issuer.sv
// Directed bench for fpu_long_issuer: the bench plays the FPU and the writeback consumer,
// expected writebacks go through a scoreboard queue.
module tb_fpu_long_issuer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [31:0] req_x, req_y, req_z;
  logic [4:0]  req_funct5, req_rd;
  logic [2:0]  req_rm;
  logic        flush;
  logic        fpu_en;
  logic [31:0] fpu_x, fpu_y, fpu_z;
  logic [4:0]  fpu_funct5;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_res;
  logic        fpu_valid;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        busy, timeout_err;

  always #5 clk = ~clk;

  fpu_long_issuer #(.TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .req_funct5(req_funct5), .req_rm(req_rm), .req_rd(req_rd),
    .flush(flush), .fpu_en(fpu_en),
    .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_z(fpu_z),
    .fpu_funct5(fpu_funct5), .fpu_rm(fpu_rm),
    .fpu_res(fpu_res), .fpu_valid(fpu_valid),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .busy(busy), .timeout_err(timeout_err)
  );

  logic [36:0] sb[$];
  int passed = 0;
  int total  = 0;
  int en_cnt = 0;
  int spur   = 0;
  int base;

  // Count start pulses and any writeback offered while nothing is expected.
  always @(negedge clk) begin
    if (fpu_en) en_cnt <= en_cnt + 1;
    if (wb_valid && sb.size() == 0) spur <= spur + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                      input logic [4:0] f, input logic [2:0] rm, input logic [4:0] rd);
    req_x = x; req_y = y; req_z = z;
    req_funct5 = f; req_rm = rm; req_rd = rd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wb_check(input string tag);
    check1({tag, "_wb_valid"}, wb_valid, 1'b1);
    check1({tag, "_sb_has_entry"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      check32({tag, "_wb_data"}, wb_data, sb[0][36:5]);
      check32({tag, "_wb_rd"}, 32'(wb_rd), 32'(sb[0][4:0]));
    end
  endtask

  task automatic retire();
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; flush = 1'b0; fpu_valid = 1'b0; wb_ready = 1'b0;
    req_x = '0; req_y = '0; req_z = '0; req_funct5 = '0; req_rm = '0; req_rd = '0;
    fpu_res = '0;
    tick(); tick();
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_fpu_en", fpu_en, 1'b0);
    check1("rst_wb_valid", wb_valid, 1'b0);
    check1("rst_timeout_err", timeout_err, 1'b0);
    check32("rst_wb_data", wb_data, 32'h0);
    check32("rst_wb_rd", 32'(wb_rd), 32'h0);
    check32("rst_fpu_x", fpu_x, 32'h0);
    check32("rst_fpu_funct5", 32'(fpu_funct5), 32'h0);
    check32("rst_fpu_rm", 32'(fpu_rm), 32'h0);
    rstn = 1'b1;
    tick();
    check1("post_rst_req_ready", req_ready, 1'b1);

    // Basic op: result four cycles after the start pulse.
    wb_ready = 1'b1;
    base = en_cnt;
    send(32'h3F800000, 32'h0, 32'h0, 5'h0B, 3'd1, 5'd5);
    check1("t1_fpu_en", fpu_en, 1'b1);
    check32("t1_fpu_x", fpu_x, 32'h3F800000);
    check32("t1_fpu_funct5", 32'(fpu_funct5), 32'h0B);
    check32("t1_fpu_rm", 32'(fpu_rm), 32'd1);
    check1("t1_req_ready", req_ready, 1'b0);
    tick(); tick(); tick(); tick();
    check1("t1_fpu_en_off", fpu_en, 1'b0);
    check32("t1_fpu_x_stable", fpu_x, 32'h3F800000);
    fpu_res = 32'h40000000; fpu_valid = 1'b1;
    sb.push_back({32'h40000000, 5'd5});
    tick();
    fpu_valid = 1'b0;
    wb_check("t1");
    tick();
    retire();
    check1("t1_wb_done", wb_valid, 1'b0);
    check1("t1_req_ready_back", req_ready, 1'b1);
    check32("t1_single_en_pulse", en_cnt - base, 32'd1);

    // Writeback stalled for three cycles with a stray FPU strobe in HOLD.
    wb_ready = 1'b0;
    send(32'h11111111, 32'h22222222, 32'h33333333, 5'h10, 3'd2, 5'd9);
    tick();
    fpu_res = 32'h12345678; fpu_valid = 1'b1;
    sb.push_back({32'h12345678, 5'd9});
    tick();
    fpu_valid = 1'b0;
    wb_check("t2_hold1");
    check1("t2_req_ready1", req_ready, 1'b0);
    fpu_res = 32'hDEADBEEF; fpu_valid = 1'b1;
    tick();
    fpu_valid = 1'b0;
    wb_check("t2_hold2");
    check1("t2_req_ready2", req_ready, 1'b0);
    check32("t2_fpu_z_stable", fpu_z, 32'h33333333);
    tick();
    wb_check("t2_hold3");
    check1("t2_req_ready3", req_ready, 1'b0);
    wb_ready = 1'b1;
    tick();
    retire();
    check1("t2_wb_done", wb_valid, 1'b0);
    check1("t2_req_ready_back", req_ready, 1'b1);

    // Flush two cycles into WAIT, late result is discarded.
    send(32'h1, 32'h2, 32'h3, 5'h01, 3'd0, 5'd3);
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check1("t3_drain_busy", busy, 1'b1);
    check1("t3_drain_req_ready", req_ready, 1'b0);
    tick(); tick();
    fpu_res = 32'hCAFEF00D; fpu_valid = 1'b1;
    check1("t3_busy_at_valid", busy, 1'b1);
    tick();
    fpu_valid = 1'b0;
    check1("t3_busy_dropped", busy, 1'b0);
    check1("t3_no_wb", wb_valid, 1'b0);
    check1("t3_req_ready", req_ready, 1'b1);
    // Next op is accepted and completes with its result arriving during ISSUE.
    send(32'h4, 32'h5, 32'h6, 5'h02, 3'd3, 5'd7);
    check1("t3b_fpu_en", fpu_en, 1'b1);
    fpu_res = 32'h0BADF00D; fpu_valid = 1'b1;
    sb.push_back({32'h0BADF00D, 5'd7});
    tick();
    fpu_valid = 1'b0;
    wb_check("t3b");
    tick();
    retire();
    check1("t3b_req_ready", req_ready, 1'b1);

    // Flush coincident with the result in WAIT.
    send(32'h7, 32'h8, 32'h9, 5'h03, 3'd0, 5'd4);
    tick();
    flush = 1'b1; fpu_valid = 1'b1; fpu_res = 32'h77777777;
    tick();
    flush = 1'b0; fpu_valid = 1'b0;
    check1("t4_busy", busy, 1'b0);
    check1("t4_req_ready", req_ready, 1'b1);
    check1("t4_no_wb", wb_valid, 1'b0);

    // Flush during ISSUE still pulses fpu_en once; DRAIN ignores a second flush.
    base = en_cnt;
    send(32'hA, 32'hB, 32'hC, 5'h04, 3'd0, 5'd8);
    flush = 1'b1;
    check1("t5_fpu_en", fpu_en, 1'b1);
    tick();
    check1("t5_drain_busy", busy, 1'b1);
    check1("t5_fpu_en_off", fpu_en, 1'b0);
    tick();
    check1("t5_drain_ignores_flush", busy, 1'b1);
    flush = 1'b0; fpu_valid = 1'b1; fpu_res = 32'h12121212;
    tick();
    fpu_valid = 1'b0;
    check1("t5_idle", busy, 1'b0);
    check1("t5_no_wb", wb_valid, 1'b0);
    check32("t5_single_en_pulse", en_cnt - base, 32'd1);

    // Flush in HOLD with wb_ready high: no writeback.
    send(32'hD, 32'hE, 32'hF, 5'h05, 3'd0, 5'd2);
    tick();
    fpu_res = 32'h55555555; fpu_valid = 1'b1;
    sb.push_back({32'h55555555, 5'd2});
    tick();
    fpu_valid = 1'b0;
    wb_check("t6");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    retire();
    check1("t6_wb_dropped", wb_valid, 1'b0);
    check1("t6_req_ready", req_ready, 1'b1);

    // Flush in IDLE blocks the transfer.
    req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check1("t7_no_transfer", busy, 1'b0);
    check1("t7_no_en", fpu_en, 1'b0);

    // Timeout with TIMEOUT=8: WAIT lasts counter values 0..7.
    send(32'h10, 32'h20, 32'h30, 5'h06, 3'd0, 5'd1);
    tick();
    repeat (7) tick();
    check1("t8_busy_at_last", busy, 1'b1);
    check1("t8_no_err_yet", timeout_err, 1'b0);
    tick();
    check1("t8_timeout_err", timeout_err, 1'b1);
    check1("t8_idle", busy, 1'b0);
    check1("t8_req_ready", req_ready, 1'b1);
    check1("t8_no_wb", wb_valid, 1'b0);
    send(32'h40, 32'h50, 32'h60, 5'h07, 3'd0, 5'd6);
    fpu_res = 32'h89ABCDEF; fpu_valid = 1'b1;
    sb.push_back({32'h89ABCDEF, 5'd6});
    tick();
    fpu_valid = 1'b0;
    wb_check("t8b");
    tick();
    retire();
    check1("t8_err_sticky", timeout_err, 1'b1);

    // Reset in the middle of WAIT, result arriving after release is ignored.
    send(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 5'h08, 3'd4, 5'd12);
    tick(); tick();
    rstn = 1'b0;
    #1;
    check1("t9_rst_busy", busy, 1'b0);
    check1("t9_rst_err", timeout_err, 1'b0);
    check1("t9_rst_fpu_en", fpu_en, 1'b0);
    check1("t9_rst_req_ready", req_ready, 1'b1);
    check32("t9_rst_fpu_x", fpu_x, 32'h0);
    check32("t9_rst_fpu_y", fpu_y, 32'h0);
    check32("t9_rst_wb_data", wb_data, 32'h0);
    check32("t9_rst_wb_rd", 32'(wb_rd), 32'h0);
    tick();
    rstn = 1'b1;
    fpu_res = 32'h99999999; fpu_valid = 1'b1;
    tick();
    fpu_valid = 1'b0;
    check1("t9_no_wb", wb_valid, 1'b0);
    check32("t9_wb_data_kept", wb_data, 32'h0);
    check1("t9_idle", busy, 1'b0);
    tick();
    check1("t9_no_wb_later", wb_valid, 1'b0);

    check32("no_spurious_wb", spur, 32'd0);
    check32("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
